// File: rtl/poker_frame_tx.sv
// Frame transmitter for the card link: wraps a hand, single, pair or first notice into
// SOF/TYPE/payload/CHK and feeds it to uart_tx one byte per tx_done handshake.
module poker_frame_tx #(
    parameter logic [7:0]  SOF_BYTE   = 8'hAA,
    parameter logic [15:0] GAP_CYCLES = 16'd0,
    parameter logic [19:0] TX_TIMEOUT = 20'd200_000
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         hand_valid,
    input  logic [135:0] hand_data,
    input  logic         one_valid,
    input  logic [7:0]   one_data,
    input  logic         two_valid,
    input  logic [15:0]  two_data,
    input  logic         first_valid,
    input  logic         tx_done,
    output logic [7:0]   tx_byte,
    output logic         tx_flag,
    output logic         busy,
    output logic         frame_done,
    output logic         frame_err,
    output logic         req_drop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [135:0]   payload_q, payload_d;
    logic [7:0]     type_q, type_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     chk_q, chk_d;
    logic [15:0]    gap_q, gap_d;
    logic [19:0]    wait_q, wait_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           req_drop_q, req_drop_d;

    logic [2:0]     n_valid;
    logic           any_valid;
    logic [4:0]     last_idx;
    logic [7:0]     next_byte;
    logic           load_byte;

    assign n_valid   = {2'b00, first_valid} + {2'b00, hand_valid}
                     + {2'b00, two_valid} + {2'b00, one_valid};
    assign any_valid = (n_valid != 3'd0);
    assign last_idx  = cnt_q - 5'd1;

    // idx_q names the byte to be loaded next; SOF is loaded directly on acceptance.
    always_comb begin
        next_byte = payload_q[135:128];
        if (idx_q == 5'd1) begin
            next_byte = type_q;
        end else if (idx_q == last_idx) begin
            next_byte = chk_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        type_d     = type_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        gap_d      = gap_q;
        wait_d     = wait_q;
        tx_byte_d  = tx_byte_q;
        req_drop_d = 1'b0;
        load_byte  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d    = S_SEND;
                    tx_byte_d  = SOF_BYTE;
                    idx_d      = 5'd1;
                    chk_d      = 8'h00;
                    req_drop_d = (n_valid > 3'd1);
                    if (first_valid) begin
                        type_d    = 8'h04;
                        cnt_d     = 5'd3;
                        payload_d = '0;
                    end else if (hand_valid) begin
                        type_d    = 8'h01;
                        cnt_d     = 5'd20;
                        payload_d = hand_data;
                    end else if (two_valid) begin
                        type_d    = 8'h03;
                        cnt_d     = 5'd5;
                        payload_d = {two_data, 120'd0};
                    end else begin
                        type_d    = 8'h02;
                        cnt_d     = 5'd4;
                        payload_d = {one_data, 128'd0};
                    end
                end
            end
            S_SEND: begin
                req_drop_d = any_valid;
                wait_d     = 20'd0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                req_drop_d = any_valid;
                if (tx_done) begin
                    if (idx_q == cnt_q) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES == 16'd0) begin
                        state_d   = S_SEND;
                        load_byte = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 16'd0;
                    end
                end else if (wait_q == TX_TIMEOUT - 20'd1) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 20'd1;
                end
            end
            S_GAP: begin
                req_drop_d = any_valid;
                if (gap_q == GAP_CYCLES - 16'd1) begin
                    state_d   = S_SEND;
                    load_byte = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_DONE: begin
                req_drop_d = any_valid;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                req_drop_d = any_valid;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Checksum folds in TYPE and payload as they are loaded; only payload bytes shift.
        if (load_byte) begin
            tx_byte_d = next_byte;
            idx_d     = idx_q + 5'd1;
            if (idx_q != last_idx) begin
                chk_d = chk_q ^ next_byte;
            end
            if ((idx_q != 5'd1) && (idx_q != last_idx)) begin
                payload_d = {payload_q[127:0], 8'h00};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            payload_q  <= '0;
            type_q     <= 8'h00;
            cnt_q      <= 5'd0;
            idx_q      <= 5'd0;
            chk_q      <= 8'h00;
            gap_q      <= 16'd0;
            wait_q     <= 20'd0;
            tx_byte_q  <= 8'h00;
            req_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            type_q     <= type_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            gap_q      <= gap_d;
            wait_q     <= wait_d;
            tx_byte_q  <= tx_byte_d;
            req_drop_q <= req_drop_d;
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_flag    = (state_q == S_SEND);
    assign busy       = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_GAP);
    assign frame_done = (state_q == S_DONE);
    assign frame_err  = (state_q == S_ERR);
    assign req_drop   = req_drop_q;

endmodule
